// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared constants for the pipelined instruction-memory fetch
//                unit. Holds the NOP word, fault codes and a helper that
//                gives the packed width of one {instr, pc, fault} response.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

  // Instruction returned in place of memory data on a faulting fetch
  localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

  // Fault codes carried on rsp_fault
  localparam int          FAULT_W        = 2;
  localparam logic [1:0]  FAULT_OK       = 2'b00;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
  localparam logic [1:0]  FAULT_RANGE    = 2'b10;

  // Packed response width: {instr, pc, fault}
  function automatic int rsp_width(input int data_w, input int addr_w);
    return data_w + addr_w + FAULT_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : imem_rsp_fifo
//  Description : Two-entry response FIFO holding packed {instr, pc, fault}
//                records. flush empties it at the next clock edge and
//                overrides any push/pop presented in the same cycle.
//  Ports       : clk, rst_n (async, active-low)
//                flush            - drop all stored entries
//                push, push_data  - write one record (ignored when full)
//                pop              - retire head record (ignored when empty)
//                empty, count     - fill status (count 0..2)
//                head             - record at the head of the FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int WIDTH = 66
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] r_slot [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~flush & (r_count != 2'd2);
  assign w_pop  = pop  & ~flush & (r_count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot[0] <= '0;
      r_slot[1] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
    end else if (flush) begin
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_slot[r_wptr] <= push_data;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign empty = (r_count == 2'd0);
  assign count = r_count;
  assign head  = r_slot[r_rptr];

endmodule
`default_nettype wire

// File: rtl/imem_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_unit
//  Description : Instruction memory with a valid/ready fetch port. An accepted
//                PC is read into an in-flight register and is presented on the
//                response port the following cycle; a two-entry FIFO absorbs
//                IF-stage back-pressure. flush drops everything in flight or
//                buffered while letting a same-cycle request (branch target)
//                through one cycle later than normal.
//  Ports       : clk, rst_n (async, active-low)
//                req_valid/req_ready/req_pc        - fetch request
//                flush                             - discard stale fetches
//                rsp_valid/rsp_ready               - response handshake
//                rsp_instr/rsp_pc/rsp_fault        - response payload
//                ld_en/ld_addr/ld_data             - program-load write port
//  Config      : IMEM_LOAD_PORT_EN - when defined, ld_* writes the memory
//                (read-first); otherwise ld_* are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = "code.hex"
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_pc,
  input  logic                     flush,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_instr,
  output logic [ADDR_W-1:0]        rsp_pc,
  output logic [1:0]               rsp_fault,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_W-1:0]        ld_data
);

  localparam int                RSP_W   = rsp_width(DATA_W, ADDR_W);
  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] c_depth = ADDR_W'(DEPTH);

  // --------------------------------------------------------------------------
  // Memory array (contents survive reset)
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];

`ifdef IMEM_LOAD_PORT_EN
  // Write lands at the edge; a fetch of the same word in this cycle samples
  // the old contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (ld_en && (32'(ld_addr) < DEPTH)) begin
      r_mem[ld_addr] <= ld_data;
    end
  end
`else
  logic w_unused_ld;
  assign w_unused_ld = ^{ld_en, ld_addr, ld_data};
`endif

  // --------------------------------------------------------------------------
  // Fault decode and read data
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_word;
  logic [1:0]        w_fault;
  logic [DATA_W-1:0] w_mem_q;
  logic [DATA_W-1:0] w_instr;

  assign w_word = req_pc >> 2;

  always_comb begin
    w_fault = FAULT_OK;
    if (req_pc[1:0] != 2'b00) begin
      w_fault = FAULT_MISALIGN;      // misalignment wins over range
    end else if (w_word >= c_depth) begin
      w_fault = FAULT_RANGE;
    end
  end

  assign w_mem_q = r_mem[w_word[IDX_W-1:0]];
  assign w_instr = (w_fault == FAULT_OK) ? w_mem_q : DATA_W'(IMEM_NOP);

  // --------------------------------------------------------------------------
  // In-flight register, FIFO and occupancy
  // --------------------------------------------------------------------------
  logic             r_if_valid;
  logic [RSP_W-1:0] r_if_data;
  logic             r_flush_d;

  logic             w_fifo_empty;
  logic [1:0]       w_fifo_count;
  logic [RSP_W-1:0] w_fifo_head;
  logic [1:0]       w_occ;
  logic             w_accept;
  logic             w_pop;
  logic             w_pop_if;
  logic             w_pop_fifo;
  logic             w_push_fifo;
  logic [RSP_W-1:0] w_head;

  assign w_occ = {1'b0, r_if_valid} + w_fifo_count;

  // A flush frees every slot at the coming edge, so the branch target can
  // always be taken in the flush cycle even when the buffer is full.
  assign req_ready = flush | (w_occ < 2'd2);
  assign w_accept  = req_valid & req_ready;

  // The in-flight entry is the head only while the FIFO is empty. A request
  // that survived a flush is held back for one cycle so the cycle after a
  // flush never shows a response.
  assign rsp_valid   = ~w_fifo_empty | (r_if_valid & ~r_flush_d);
  assign w_head      = w_fifo_empty ? r_if_data : w_fifo_head;
  assign w_pop       = rsp_valid & rsp_ready & ~flush;
  assign w_pop_if    = w_pop & w_fifo_empty;
  assign w_pop_fifo  = w_pop & ~w_fifo_empty;
  assign w_push_fifo = r_if_valid & ~w_pop_if;

  assign {rsp_instr, rsp_pc, rsp_fault} = w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid <= 1'b0;
      r_if_data  <= '0;
      r_flush_d  <= 1'b0;
    end else begin
      r_if_valid <= w_accept;
      r_flush_d  <= flush;
      if (w_accept) begin
        r_if_data <= {w_instr, req_pc, w_fault};
      end
    end
  end

  imem_rsp_fifo #(
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (w_push_fifo),
    .push_data (r_if_data),
    .pop       (w_pop_fifo),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count),
    .head      (w_fifo_head)
  );

endmodule
`default_nettype wire
